// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg -- definitions shared by the CPU memory responder and related paths.
//   state_t       : bus-cycle FSM encoding (IDLE -> ACCESS -> STROBE -> IDLE)
//   region_t      : decoded target of a bus cycle (boot ROM or external SRAM)
//   decode_region : picks the region from address bits [19:16]
// ---------------------------------------------------------------------------
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_STROBE = 2'd2
   } state_t;

   typedef enum logic {
      REG_SRAM = 1'b0,
      REG_ROM  = 1'b1
   } region_t;

   // Largest wait count that fits the 4-bit wait counter.
   localparam logic [3:0] WAIT_MAX = 4'd15;

   // The boot ROM occupies one 64 KiB page; everything else is SRAM.
   function automatic region_t decode_region(input logic [3:0] page,
                                             input logic [3:0] rom_page);
      region_t region;
      if (page == rom_page) begin
         region = REG_ROM;
      end else begin
         region = REG_SRAM;
      end
      return region;
   endfunction

endpackage

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder -- serves byte reads/writes from the CPU core out of a
// synchronous boot ROM page or an asynchronous external SRAM, and advances
// the core with a single-clock ce strobe when each bus cycle completes.
//
// Parameters
//   SRAM_WAIT   : SRAM access cycles per byte (1..15)
//   ROM_PAGE    : value of address[19:16] that selects the boot ROM
// Ports
//   clock       : sole clock, all state on its rising edge
//   reset_n     : asynchronous active-low reset
//   hold        : blocks the launch of a new bus cycle while high
//   cpu_address : byte address from the core
//   cpu_out     : write data from the core
//   cpu_we      : write request from the core
//   cpu_in      : read data returned to the core (held between reads)
//   ce          : one-clock core advance strobe
//   rom_address : ROM address, rom_q is sampled at the end of ACCESS
//   rom_q       : ROM read data
//   sram_*      : SRAM pins (address, data in/out, active-low OE/WE,
//                 data-bus output enable)
// ---------------------------------------------------------------------------
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned SRAM_WAIT = 2,
   parameter logic [3:0]  ROM_PAGE  = 4'hF
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        hold,
   input  logic [19:0] cpu_address,
   input  logic [7:0]  cpu_out,
   input  logic        cpu_we,
   output logic [7:0]  cpu_in,
   output logic        ce,
   output logic [15:0] rom_address,
   input  logic [7:0]  rom_q,
   output logic [19:0] sram_address,
   input  logic [7:0]  sram_din,
   output logic [7:0]  sram_dout,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        sram_dq_oe
);

   // Counter starts at SRAM_WAIT-1 so it reaches 0 on the last ACCESS cycle.
   localparam logic [3:0] WAIT_LOAD = 4'(SRAM_WAIT - 1);

   state_t      state_q, state_d;
   region_t     region_q, region_d;
   logic        we_q, we_d;
   logic [3:0]  wait_q, wait_d;
   logic [7:0]  cpu_in_q, cpu_in_d;
   logic        ce_q, ce_d;
   logic [15:0] rom_address_q, rom_address_d;
   logic [19:0] sram_address_q, sram_address_d;
   logic [7:0]  sram_dout_q, sram_dout_d;
   logic        sram_oe_n_q, sram_oe_n_d;
   logic        sram_we_n_q, sram_we_n_d;
   logic        sram_dq_oe_q, sram_dq_oe_d;

   // Next-state and registered-output logic for the bus-cycle FSM.
   always_comb begin
      state_d        = state_q;
      region_d       = region_q;
      we_d           = we_q;
      wait_d         = wait_q;
      cpu_in_d       = cpu_in_q;
      ce_d           = 1'b0;
      rom_address_d  = rom_address_q;
      sram_address_d = sram_address_q;
      sram_dout_d    = sram_dout_q;
      sram_oe_n_d    = sram_oe_n_q;
      sram_we_n_d    = sram_we_n_q;
      sram_dq_oe_d   = sram_dq_oe_q;

      case (state_q)
         ST_IDLE: begin
            if (!hold) begin
               state_d     = ST_ACCESS;
               region_d    = decode_region(cpu_address[19:16], ROM_PAGE);
               we_d        = cpu_we;
               wait_d      = WAIT_LOAD;
               sram_dout_d = cpu_out;
               if (decode_region(cpu_address[19:16], ROM_PAGE) == REG_ROM) begin
                  rom_address_d = cpu_address[15:0];
               end else begin
                  // Address is only loaded here, so it is stable for all of ACCESS.
                  sram_address_d = cpu_address;
                  if (cpu_we) begin
                     sram_we_n_d  = 1'b0;
                     sram_dq_oe_d = 1'b1;
                  end else begin
                     sram_oe_n_d  = 1'b0;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_ACCESS: begin
            if (region_q == REG_ROM) begin
               // ROM takes one ACCESS cycle; writes to it are dropped.
               state_d = ST_STROBE;
               ce_d    = 1'b1;
               if (!we_q) begin
                  cpu_in_d = rom_q;
               end else begin
                  cpu_in_d = cpu_in_q;
               end
            end else if (wait_q == 4'd0) begin
               // Last SRAM cycle: sample read data and release OE/WE.
               // dq_oe stays on through STROBE for write data hold time.
               state_d     = ST_STROBE;
               ce_d        = 1'b1;
               sram_oe_n_d = 1'b1;
               sram_we_n_d = 1'b1;
               if (!we_q) begin
                  cpu_in_d = sram_din;
               end else begin
                  cpu_in_d = cpu_in_q;
               end
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end

         ST_STROBE: begin
            state_d      = ST_IDLE;
            sram_dq_oe_d = 1'b0;
         end

         default: begin
            state_d      = ST_IDLE;
            sram_oe_n_d  = 1'b1;
            sram_we_n_d  = 1'b1;
            sram_dq_oe_d = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset to a quiet bus.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         region_q       <= REG_SRAM;
         we_q           <= 1'b0;
         wait_q         <= 4'd0;
         cpu_in_q       <= 8'h00;
         ce_q           <= 1'b0;
         rom_address_q  <= 16'h0000;
         sram_address_q <= 20'h00000;
         sram_dout_q    <= 8'h00;
         sram_oe_n_q    <= 1'b1;
         sram_we_n_q    <= 1'b1;
         sram_dq_oe_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         region_q       <= region_d;
         we_q           <= we_d;
         wait_q         <= wait_d;
         cpu_in_q       <= cpu_in_d;
         ce_q           <= ce_d;
         rom_address_q  <= rom_address_d;
         sram_address_q <= sram_address_d;
         sram_dout_q    <= sram_dout_d;
         sram_oe_n_q    <= sram_oe_n_d;
         sram_we_n_q    <= sram_we_n_d;
         sram_dq_oe_q   <= sram_dq_oe_d;
      end
   end

   assign cpu_in       = cpu_in_q;
   assign ce           = ce_q;
   assign rom_address  = rom_address_q;
   assign sram_address = sram_address_q;
   assign sram_dout    = sram_dout_q;
   assign sram_oe_n    = sram_oe_n_q;
   assign sram_we_n    = sram_we_n_q;
   assign sram_dq_oe   = sram_dq_oe_q;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder -- self-checking bench for mem_responder.
// A transaction-level model predicts every output on every clock from the
// bus-cycle timeline (launch, ACCESS count, STROBE); SRAM and ROM devices are
// modelled behind the pins. Directed cases pin literal values, then random
// traffic runs against the model. A second instance with SRAM_WAIT=1 runs
// back-to-back reads.
// ---------------------------------------------------------------------------
module tb_mem_responder;

   localparam int         W  = 2;
   localparam logic [3:0] RP = 4'hF;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        hold;
   logic [19:0] cpu_address;
   logic [7:0]  cpu_out;
   logic        cpu_we;
   logic [7:0]  cpu_in;
   logic        ce;
   logic [15:0] rom_address;
   logic [7:0]  rom_q;
   logic [19:0] sram_address;
   logic [7:0]  sram_din;
   logic [7:0]  sram_dout;
   logic        sram_oe_n;
   logic        sram_we_n;
   logic        sram_dq_oe;

   // second instance: SRAM_WAIT=1, continuous reads
   logic        hold1 = 1'b0;
   logic [19:0] cpu_address1 = 20'h00010;
   logic [7:0]  cpu_out1 = 8'h00;
   logic        cpu_we1 = 1'b0;
   logic [7:0]  cpu_in1;
   logic        ce1;
   logic [15:0] rom_address1;
   logic [7:0]  rom_q1 = 8'h00;
   logic [19:0] sram_address1;
   logic [7:0]  sram_din1 = 8'hC3;
   logic [7:0]  sram_dout1;
   logic        sram_oe_n1, sram_we_n1, sram_dq_oe1;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mem_responder #(.SRAM_WAIT(W), .ROM_PAGE(RP)) u_dut (
      .clock(clock), .reset_n(reset_n), .hold(hold),
      .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
      .cpu_in(cpu_in), .ce(ce), .rom_address(rom_address), .rom_q(rom_q),
      .sram_address(sram_address), .sram_din(sram_din), .sram_dout(sram_dout),
      .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_dq_oe(sram_dq_oe)
   );

   mem_responder #(.SRAM_WAIT(1), .ROM_PAGE(RP)) u_dut_w1 (
      .clock(clock), .reset_n(reset_n), .hold(hold1),
      .cpu_address(cpu_address1), .cpu_out(cpu_out1), .cpu_we(cpu_we1),
      .cpu_in(cpu_in1), .ce(ce1), .rom_address(rom_address1), .rom_q(rom_q1),
      .sram_address(sram_address1), .sram_din(sram_din1), .sram_dout(sram_dout1),
      .sram_oe_n(sram_oe_n1), .sram_we_n(sram_we_n1), .sram_dq_oe(sram_dq_oe1)
   );

   function automatic logic [7:0] rom_fn(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hC8;
   endfunction

   function automatic logic [6:0] key_of(input logic [19:0] a);
      return {a[19:16], a[2:0]};
   endfunction

   function automatic logic [7:0] init_fn(input logic [6:0] k);
      return {1'b0, k} ^ 8'h96;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- device models ----------------
   logic [7:0] dev_mem [128];
   assign sram_din = dev_mem[key_of(sram_address)];
   assign rom_q    = rom_fn(rom_address);

   initial begin
      for (int i = 0; i < 128; i++) dev_mem[i] = init_fn(7'(i));
      forever begin
         @(negedge clock);
         if (sram_we_n === 1'b0 && sram_dq_oe === 1'b1)
            dev_mem[key_of(sram_address)] = sram_dout;
      end
   end

   // ---------------- transaction-level model ----------------
   // m_k = clock index within current cycle (0 idle, 1..m_len), m_len = latency
   int         m_k = 0;
   int         m_len = 0;
   logic [19:0] m_addr = 20'h0;
   logic [7:0]  m_data = 8'h0;
   logic [7:0]  m_cpu_in = 8'h0;
   logic        m_we = 1'b0;
   logic        m_rom = 1'b0;
   logic [7:0]  shadow [128];

   initial begin
      for (int i = 0; i < 128; i++) shadow[i] = init_fn(7'(i));
      forever begin
         @(posedge clock or negedge reset_n);
         if (reset_n !== 1'b1) begin
            m_k = 0;
            m_cpu_in = 8'h00;
         end else if (m_k == 0) begin
            if (hold == 1'b0) begin
               m_addr = cpu_address;
               m_data = cpu_out;
               m_we   = cpu_we;
               m_rom  = (cpu_address[19:16] == RP);
               m_len  = m_rom ? 2 : W + 1;
               m_k    = 1;
               if (m_we && !m_rom) shadow[key_of(m_addr)] = m_data;
            end
         end else if (m_k == m_len) begin
            m_k = 0;
         end else begin
            m_k = m_k + 1;
            if (m_k == m_len && !m_we)
               m_cpu_in = m_rom ? rom_fn(m_addr[15:0]) : shadow[key_of(m_addr)];
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      logic prev_ce;
      logic acc, stb, sr;
      prev_ce = 1'b0;
      forever begin
         @(negedge clock);
         acc = (m_k != 0) && (m_k < m_len);
         stb = (m_k != 0) && (m_k == m_len);
         sr  = !m_rom;
         chk("ce", 32'(ce), 32'(stb));
         chk("sram_oe_n", 32'(sram_oe_n), 32'(!(acc && sr && !m_we)));
         chk("sram_we_n", 32'(sram_we_n), 32'(!(acc && sr && m_we)));
         chk("sram_dq_oe", 32'(sram_dq_oe), 32'((m_k != 0) && sr && m_we));
         if (acc && sr) chk("sram_address", 32'(sram_address), 32'(m_addr));
         if ((m_k != 0) && sr && m_we) chk("sram_dout", 32'(sram_dout), 32'(m_data));
         if (acc && m_rom) chk("rom_address", 32'(rom_address), 32'(m_addr[15:0]));
         chk("cpu_in", 32'(cpu_in), 32'(m_cpu_in));
         chk("ce_adjacent", 32'(ce & prev_ce), 32'(1'b0));
         prev_ce = ce;
      end
   end

   // ---------------- stimulus ----------------
   task automatic launch(input logic [19:0] a, input logic [7:0] d, input logic w);
      int g;
      g = 0;
      while (m_k != 0 && g < 20) begin
         @(negedge clock);
         g++;
      end
      cpu_address = a;
      cpu_out     = d;
      cpu_we      = w;
      hold        = 1'b0;
      @(negedge clock);
      hold        = 1'b1;
   endtask

   initial begin
      int g;
      reset_n = 1'b0;
      hold = 1'b1;
      cpu_address = 20'h0;
      cpu_out = 8'h0;
      cpu_we = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_ce", 32'(ce), 32'h0);
      chk("rst_cpu_in", 32'(cpu_in), 32'h0);
      chk("rst_oe_n", 32'(sram_oe_n), 32'h1);
      chk("rst_we_n", 32'(sram_we_n), 32'h1);
      chk("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
      chk("rst_sram_address", 32'(sram_address), 32'h0);
      chk("rst_rom_address", 32'(rom_address), 32'h0);
      chk("rst_sram_dout", 32'(sram_dout), 32'h0);
      reset_n = 1'b1;
      @(negedge clock);

      // ROM read F0123 -> EA, ce in clock 2
      launch(20'hF0123, 8'h00, 1'b0);
      chk("rom_addr_lit", 32'(rom_address), 32'h0123);
      chk("rom_ce_clk1", 32'(ce), 32'h0);
      @(negedge clock);
      chk("rom_ce_clk2", 32'(ce), 32'h1);
      chk("rom_data_lit", 32'(cpu_in), 32'hEA);
      @(negedge clock);

      // SRAM write 5A to 01234
      launch(20'h01234, 8'h5A, 1'b1);
      chk("wr_we_n_clk1", 32'(sram_we_n), 32'h0);
      chk("wr_addr_lit", 32'(sram_address), 32'h01234);
      @(negedge clock);
      chk("wr_we_n_clk2", 32'(sram_we_n), 32'h0);
      @(negedge clock);
      chk("wr_ce_clk3", 32'(ce), 32'h1);
      chk("wr_we_n_strobe", 32'(sram_we_n), 32'h1);
      chk("wr_dq_oe_strobe", 32'(sram_dq_oe), 32'h1);
      chk("wr_cpu_in_kept", 32'(cpu_in), 32'hEA);
      @(negedge clock);
      chk("wr_dq_oe_off", 32'(sram_dq_oe), 32'h0);

      // readback 01234
      launch(20'h01234, 8'h00, 1'b0);
      chk("rd_oe_n_clk1", 32'(sram_oe_n), 32'h0);
      @(negedge clock);
      chk("rd_oe_n_clk2", 32'(sram_oe_n), 32'h0);
      @(negedge clock);
      chk("rd_ce_clk3", 32'(ce), 32'h1);
      chk("rd_data_lit", 32'(cpu_in), 32'h5A);
      @(negedge clock);

      // ROM-region write F0000: discarded, ce at clock 2
      launch(20'hF0000, 8'h77, 1'b1);
      chk("romwr_we_n", 32'(sram_we_n), 32'h1);
      @(negedge clock);
      chk("romwr_ce_clk2", 32'(ce), 32'h1);
      chk("romwr_cpu_in", 32'(cpu_in), 32'h5A);
      @(negedge clock);

      // hold for 5 clocks, then nominal latency after release
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("hold_no_ce", 32'(ce), 32'h0);
      end
      launch(20'h01234, 8'h00, 1'b0);
      chk("hold_rel_clk1", 32'(ce), 32'h0);
      @(negedge clock);
      chk("hold_rel_clk2", 32'(ce), 32'h0);
      @(negedge clock);
      chk("hold_rel_clk3", 32'(ce), 32'h1);
      @(negedge clock);

      // reset pulse during an SRAM write
      launch(20'h01235, 8'h33, 1'b1);
      chk("rstwr_we_n_low", 32'(sram_we_n), 32'h0);
      #2 reset_n = 1'b0;
      #1;
      chk("rstwr_we_n", 32'(sram_we_n), 32'h1);
      chk("rstwr_ce", 32'(ce), 32'h0);
      chk("rstwr_dq_oe", 32'(sram_dq_oe), 32'h0);
      chk("rstwr_cpu_in", 32'(cpu_in), 32'h0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         chk("rstwr_no_strobe", 32'(ce), 32'h0);
      end

      // back-to-back reads on the SRAM_WAIT=1 instance: period 3
      g = 0;
      while (ce1 !== 1'b1 && g < 10) begin
         @(negedge clock);
         g++;
      end
      chk("b2b_ce_seen", 32'(ce1), 32'h1);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clock);
         chk("b2b_ce_period", 32'(ce1), 32'((i % 3) == 0));
         if ((i % 3) == 0) chk("b2b_data", 32'(cpu_in1), 32'hC3);
      end

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         logic [3:0] pg;
         logic [2:0] lo;
         pg = ($urandom_range(0, 3) == 0) ? RP : 4'($urandom_range(0, 14));
         lo = 3'($urandom_range(0, 7));
         cpu_address = {pg, 12'h123, 1'b0, lo};
         cpu_out     = 8'($urandom);
         cpu_we      = ($urandom_range(0, 1) == 1);
         hold        = ($urandom_range(0, 3) == 0);
         @(negedge clock);
      end
      hold = 1'b1;
      repeat (8) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter SRAM_WAIT, default 2, range 1..15: SRAM access cycles per byte.
REQ-002 SHALL have parameter ROM_PAGE, default 4'hF: value of address[19:16] that selects boot ROM.
REQ-003 SHALL have port clock  input  1  sole clock; all state on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port hold  input  1  while high, no new bus cycle starts.
REQ-006 SHALL have port cpu_address  input  20  byte address driven by the core.
REQ-007 SHALL have port cpu_out  input  8  write data from the core.
REQ-008 SHALL have port cpu_we  input  1  write request from the core.
REQ-009 SHALL have port cpu_in  output  8  read data returned to the core.
REQ-010 SHALL have port ce  output  1  one-clock core advance strobe.
REQ-011 SHALL have port rom_address  output  16  synchronous ROM address; ROM data is valid 1 clock later.
REQ-012 SHALL have port rom_q  input  8  ROM read data.
REQ-013 SHALL have ports sram_address (out 20), sram_din (in 8), sram_dout (out 8), sram_oe_n (out 1), sram_we_n (out 1), sram_dq_oe (out 1).

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> STROBE -> IDLE.
REQ-015 In IDLE with hold=0, SHALL latch cpu_address, cpu_out and cpu_we, decode the region and enter ACCESS; with hold=1 SHALL stay in IDLE with ce=0.
REQ-016 ROM region (address[19:16]==ROM_PAGE): SHALL drive rom_address=address[15:0], spend exactly 1 ACCESS cycle, then capture rom_q into cpu_in.
REQ-017 ROM-region writes SHALL be discarded but SHALL still complete with the normal ce strobe.
REQ-018 SRAM read: SHALL hold sram_oe_n=0 for SRAM_WAIT ACCESS cycles, sample sram_din on the last one into cpu_in, then deassert sram_oe_n.
REQ-019 SRAM write: SHALL hold sram_we_n=0 and sram_dq_oe=1 with sram_dout=latched data for SRAM_WAIT ACCESS cycles.
REQ-020 SRAM write: sram_we_n SHALL go high one cycle before sram_dq_oe drops, so STROBE carries dq_oe=1 and we_n=1.
REQ-021 sram_address SHALL be stable for the entire ACCESS phase.
REQ-022 An internal wait counter (4 bit) SHALL load SRAM_WAIT-1 on IDLE->ACCESS and decrement to 0; no wrap is permitted.
REQ-023 STROBE SHALL last exactly one clock with ce=1, then return to IDLE.
REQ-024 Latency from the IDLE sampling edge to ce high SHALL be 2 clocks for ROM and SRAM_WAIT+1 clocks for SRAM.
REQ-025 Back-to-back cycles SHALL repeat every latency+1 clocks.
REQ-026 cpu_in SHALL hold its last value except when updated at the end of a read.
REQ-027 cpu_in SHALL be unchanged by writes.
REQ-028 hold rising during ACCESS or STROBE SHALL NOT abort the current cycle; it only blocks the next IDLE launch.
REQ-029 ce SHALL never be high in two consecutive clocks.

Reset
REQ-030 On reset_n low, SHALL asynchronously force the FSM to IDLE and set ce=0, cpu_in=0, sram_oe_n=1, sram_we_n=1 and sram_dq_oe=0.
REQ-031 On reset_n low, SHALL asynchronously clear sram_address, rom_address, sram_dout and the wait counter to 0.
REQ-032 Reset mid-ACCESS SHALL abort the cycle with no ce strobe; the core re-issues its cycle after reset.
REQ-033 The first cycle after reset release SHALL be an IDLE sample.

Structure
REQ-034 FSM state encodings and region codes (REG_ROM, REG_SRAM) SHALL live in shared package mem_pkg.
REQ-035 SHALL be a single flat module; the SRAM pin timing may be a sub-module sram_phy if reused by the video path.

Verification
REQ-036 ROM read at F0123, rom model returns 8'hEA -> rom_address=16'h0123; ce high 2 clocks after the launch edge; cpu_in=8'hEA.
REQ-037 SRAM write 8'h5A to 01234, SRAM_WAIT=2 -> sram_we_n low exactly 2 clocks with sram_address=20'h01234; ce at clock 3; cpu_in unchanged.
REQ-038 Readback of 01234 -> sram_oe_n low 2 clocks; cpu_in=8'h5A at ce.
REQ-039 Write to F0000 -> sram_we_n never low, ROM untouched, ce at clock 2.
REQ-040 Back-to-back reads with SRAM_WAIT=1 -> ce period 3 clocks, never adjacent.
REQ-041 hold=1 for 5 clocks from IDLE -> ce stays 0; first ce follows hold release by the nominal latency.
REQ-042 Reset pulse during an SRAM write -> sram_we_n=1 and ce=0 immediately; no strobe emitted after release.
